// File: rtl/comp_thresh_wr_ctrl_if.sv
// Slow-control write port, load-FSM handshake and status of the comparator-threshold
// DAC write front end.
interface comp_thresh_wr_ctrl_if;
  logic        wr_stb;
  logic [11:0] wr_data;
  logic        clr_err;
  logic        shft_ena;
  logic        set_done;
  logic        start;
  logic        sdata;
  logic        busy;
  logic        overrun;
  logic        shift_err;
  logic        tmo_err;

  modport slave (
    input  wr_stb, wr_data, clr_err, shft_ena, set_done,
    output start, sdata, busy, overrun, shift_err, tmo_err
  );

  modport master (
    output wr_stb, wr_data, clr_err, shft_ena, set_done,
    input  start, sdata, busy, overrun, shift_err, tmo_err
  );
endinterface

// File: rtl/comp_thresh_wr_ctrl.sv
// Builds {CMD, threshold} DAC words, hands them to the load FSM via START and shifts them
// out MSB-first; keeps one pending write and sticky overrun/shift/timeout flags.
module comp_thresh_wr_ctrl #(
  parameter logic [3:0]  CMD     = 4'h3,
  parameter int unsigned TMO_CYC = 64
) (
  input logic                   clk,
  input logic                   rst_n,
  comp_thresh_wr_ctrl_if.slave  bus
);

  localparam int unsigned    TW      = $clog2(TMO_CYC + 1);
  localparam logic [TW-1:0]  TmoLast = TW'(TMO_CYC - 1);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StReq     = 2'd1;
  localparam logic [1:0] StRelease = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [15:0]   sreg_q, sreg_d;
  logic [11:0]   pend_q, pend_d;
  logic          pend_vld_q, pend_vld_d;
  logic [4:0]    bcnt_q, bcnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          start_q, start_d;
  logic          ovr_q, ovr_d;
  logic          shf_err_q, shf_err_d;
  logic          tmo_err_q, tmo_err_d;
  logic          ovr_set, shf_set, tmo_set;

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    bcnt_d     = bcnt_q;
    tmo_d      = tmo_q;
    ovr_set    = 1'b0;
    shf_set    = 1'b0;
    tmo_set    = 1'b0;

    case (state_q)
      StIdle: begin
        // A fresh strobe beats the buffered value, which then waits for the next load.
        if (bus.wr_stb) begin
          sreg_d  = {CMD, bus.wr_data};
          bcnt_d  = 5'd0;
          tmo_d   = '0;
          state_d = StReq;
        end else if (pend_vld_q) begin
          sreg_d     = {CMD, pend_q};
          pend_vld_d = 1'b0;
          bcnt_d     = 5'd0;
          tmo_d      = '0;
          state_d    = StReq;
        end
      end
      StReq: begin
        if (bus.shft_ena) begin
          sreg_d = {sreg_q[14:0], 1'b0};
          if (bcnt_q != 5'd31) bcnt_d = bcnt_q + 5'd1;
        end
        if (bus.set_done) begin
          state_d = StRelease;
          tmo_d   = '0;
          if (bcnt_q != 5'd16) shf_set = 1'b1;
        end else if (tmo_q == TmoLast) begin
          tmo_set = 1'b1;
          tmo_d   = '0;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      StRelease: begin
        if (!bus.set_done) begin
          tmo_d   = '0;
          state_d = StIdle;
        end else if (tmo_q == TmoLast) begin
          tmo_set = 1'b1;
          tmo_d   = '0;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        tmo_d   = '0;
      end
    endcase

    if (state_q != StIdle && bus.wr_stb) begin
      pend_d     = bus.wr_data;
      pend_vld_d = 1'b1;
      if (pend_vld_q) ovr_set = 1'b1;
    end

    start_d   = (state_d == StReq);
    ovr_d     = ovr_set | (ovr_q & ~bus.clr_err);
    shf_err_d = shf_set | (shf_err_q & ~bus.clr_err);
    tmo_err_d = tmo_set | (tmo_err_q & ~bus.clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sreg_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      bcnt_q     <= '0;
      tmo_q      <= '0;
      start_q    <= 1'b0;
      ovr_q      <= 1'b0;
      shf_err_q  <= 1'b0;
      tmo_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      bcnt_q     <= bcnt_d;
      tmo_q      <= tmo_d;
      start_q    <= start_d;
      ovr_q      <= ovr_d;
      shf_err_q  <= shf_err_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

  assign bus.start     = start_q;
  assign bus.sdata     = sreg_q[15];
  assign bus.busy      = (state_q != StIdle) | pend_vld_q;
  assign bus.overrun   = ovr_q;
  assign bus.shift_err = shf_err_q;
  assign bus.tmo_err   = tmo_err_q;

endmodule

// File: tb/tb_comp_thresh_wr_ctrl.sv
// Directed bench: plays the falling-edge load FSM against the write front end and checks
// serialized words, handshake timing, buffering and sticky flags.
module tb_comp_thresh_wr_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  comp_thresh_wr_ctrl_if bus_if ();

  comp_thresh_wr_ctrl #(
    .CMD     (4'h3),
    .TMO_CYC (64)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Strobe is set up on a falling edge and sampled by the following rising edge.
  task automatic wr(input logic [11:0] data);
    bus_if.wr_stb  = 1'b1;
    bus_if.wr_data = data;
    @(negedge clk);
    bus_if.wr_stb  = 1'b0;
  endtask

  task automatic clr();
    bus_if.clr_err = 1'b1;
    @(negedge clk);
    bus_if.clr_err = 1'b0;
  endtask

  // Load-FSM side: wait for START, capture SDATA each falling edge while asserting SHFT_ENA.
  task automatic shift_bits(input string tag, input int n, output logic [15:0] word);
    word = '0;
    for (int i = 0; i < 200 && !bus_if.start; i++) @(negedge clk);
    if (!bus_if.start) check({tag, "_start_wait"}, {31'd0, bus_if.start}, 32'd1);
    for (int i = 0; i < n; i++) begin
      word = {word[14:0], bus_if.sdata};
      bus_if.shft_ena = 1'b1;
      @(negedge clk);
    end
    bus_if.shft_ena = 1'b0;
  endtask

  task automatic raise_done();
    bus_if.set_done = 1'b1;
    @(negedge clk);
  endtask

  task automatic drop_done();
    bus_if.set_done = 1'b0;
    @(negedge clk);
  endtask

  logic [15:0] w;
  int          cnt;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus_if.wr_stb   = 1'b0;
    bus_if.wr_data  = '0;
    bus_if.clr_err  = 1'b0;
    bus_if.shft_ena = 1'b0;
    bus_if.set_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_start",   {31'd0, bus_if.start},     32'd0);
    check("rst_sdata",   {31'd0, bus_if.sdata},     32'd0);
    check("rst_busy",    {31'd0, bus_if.busy},      32'd0);
    check("rst_overrun", {31'd0, bus_if.overrun},   32'd0);
    check("rst_shf_err", {31'd0, bus_if.shift_err}, 32'd0);
    check("rst_tmo_err", {31'd0, bus_if.tmo_err},   32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single write 12'hA5C -> 16'h3A5C
    wr(12'hA5C);
    check("t1_start_hi", {31'd0, bus_if.start}, 32'd1);
    check("t1_sdata_b15", {31'd0, bus_if.sdata}, 32'd0);
    check("t1_busy", {31'd0, bus_if.busy}, 32'd1);
    shift_bits("t1", 16, w);
    check("t1_word", {16'd0, w}, 32'h3A5C);
    raise_done();
    check("t1_start_lo", {31'd0, bus_if.start}, 32'd0);
    check("t1_busy_rel", {31'd0, bus_if.busy}, 32'd1);
    drop_done();
    check("t1_busy_idle", {31'd0, bus_if.busy}, 32'd0);
    check("t1_errs", {29'd0, bus_if.overrun, bus_if.shift_err, bus_if.tmo_err}, 32'd0);

    // Queued writes: 111, 222 during REQ, 333 during RELEASE
    wr(12'h111);
    wr(12'h222);
    shift_bits("t2a", 16, w);
    check("t2_word1", {16'd0, w}, 32'h3111);
    raise_done();
    wr(12'h333);
    check("t2_overrun", {31'd0, bus_if.overrun}, 32'd1);
    drop_done();
    check("t2_busy_pend", {31'd0, bus_if.busy}, 32'd1);
    shift_bits("t2b", 16, w);
    check("t2_word2", {16'd0, w}, 32'h3333);
    raise_done();
    drop_done();
    @(negedge clk);
    check("t2_busy_end", {31'd0, bus_if.busy}, 32'd0);
    check("t2_overrun_end", {31'd0, bus_if.overrun}, 32'd1);
    check("t2_start_end", {31'd0, bus_if.start}, 32'd0);
    clr();
    check("t2_ovr_clr", {31'd0, bus_if.overrun}, 32'd0);

    // Short shift: 10 bits of 16'h3456 are 10'h0D1
    wr(12'h456);
    shift_bits("t3", 10, w);
    check("t3_partial", {16'd0, w}, 32'h00D1);
    raise_done();
    check("t3_shf_err", {31'd0, bus_if.shift_err}, 32'd1);
    check("t3_start_lo", {31'd0, bus_if.start}, 32'd0);
    drop_done();
    check("t3_busy_idle", {31'd0, bus_if.busy}, 32'd0);
    clr();
    check("t3_shf_clr", {31'd0, bus_if.shift_err}, 32'd0);

    // Timeout in REQ with a pending write that is retried afterwards
    wr(12'h789);
    wr(12'hABC);
    cnt = 2;
    for (int i = 0; i < 200 && bus_if.start; i++) begin
      @(negedge clk);
      if (bus_if.start) cnt++;
    end
    check("t4_start_cycles", cnt, 32'd64);
    check("t4_tmo_err", {31'd0, bus_if.tmo_err}, 32'd1);
    check("t4_busy_pend", {31'd0, bus_if.busy}, 32'd1);
    shift_bits("t4", 16, w);
    check("t4_retry_word", {16'd0, w}, 32'h3ABC);
    raise_done();
    drop_done();
    check("t4_busy_idle", {31'd0, bus_if.busy}, 32'd0);
    clr();
    check("t4_tmo_clr", {31'd0, bus_if.tmo_err}, 32'd0);

    // Reset mid-shift after 7 bits of 16'h35A5: SDATA then shows original bit 8 (=1)
    wr(12'h5A5);
    shift_bits("t5", 7, w);
    check("t5_sdata_pre", {31'd0, bus_if.sdata}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_start", {31'd0, bus_if.start}, 32'd0);
    check("t5_rst_sdata", {31'd0, bus_if.sdata}, 32'd0);
    check("t5_rst_busy",  {31'd0, bus_if.busy},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("t5_post_busy",  {31'd0, bus_if.busy},  32'd0);
    check("t5_post_start", {31'd0, bus_if.start}, 32'd0);

    // IDLE priority: strobe 0FF arrives while 0AA is pending
    wr(12'h123);
    wr(12'h0AA);
    shift_bits("t6a", 16, w);
    check("t6_word0", {16'd0, w}, 32'h3123);
    raise_done();
    drop_done();
    wr(12'h0FF);
    shift_bits("t6b", 16, w);
    check("t6_word1", {16'd0, w}, 32'h30FF);
    raise_done();
    drop_done();
    shift_bits("t6c", 16, w);
    check("t6_word2", {16'd0, w}, 32'h30AA);
    raise_done();
    drop_done();
    @(negedge clk);
    check("t6_busy_end", {31'd0, bus_if.busy}, 32'd0);
    check("t6_errs", {29'd0, bus_if.overrun, bus_if.shift_err, bus_if.tmo_err}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
